// File: rtl/npu_pkg.sv
// Shared types for the NPU phase sequencer: state and command encodings, status bit positions.
package npu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_LOADED = 3'd2,
        ST_CONV   = 3'd3,
        ST_DENSE  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        CMD_NOP   = 2'd0,
        CMD_LOAD  = 2'd1,
        CMD_RUN   = 2'd2,
        CMD_ABORT = 2'd3
    } cmd_t;

    localparam int unsigned STATUS_STATE_LSB = 0;
    localparam int unsigned STATUS_BUSY      = 3;
    localparam int unsigned STATUS_ERR_TO    = 4;
    localparam int unsigned STATUS_ERR_CMD   = 5;
    localparam int unsigned STATUS_DONE      = 6;

    // Phases guarded by the watchdog and reported as busy.
    function automatic logic in_phase(state_t s);
        return (s == ST_LOAD) || (s == ST_CONV) || (s == ST_DENSE);
    endfunction

endpackage

// File: rtl/npu_sequencer_if.sv
// Command, loader and engine handshake bundle of the NPU sequencer.
interface npu_sequencer_if;
    logic        cmd_valid;
    logic [1:0]  cmd;
    logic        cmd_ready;
    logic        load_start;
    logic        load_busy;
    logic        conv_start;
    logic        conv_done;
    logic        dense_start;
    logic        dense_done;
    logic        busy;
    logic        irq;
    logic [7:0]  status;
    logic [31:0] perf_cycles;

    // master: the sequencer itself; slave: host register block plus loader/engines.
    modport master (
        input  cmd_valid, cmd, load_busy, conv_done, dense_done,
        output cmd_ready, load_start, conv_start, dense_start, busy, irq, status, perf_cycles
    );

    modport slave (
        output cmd_valid, cmd, load_busy, conv_done, dense_done,
        input  cmd_ready, load_start, conv_start, dense_start, busy, irq, status, perf_cycles
    );
endinterface

// File: rtl/npu_watchdog.sv
// Phase watchdog: cleared on phase entry, counts while enabled, flags expiry on the last allowed cycle.
module npu_watchdog #(
    parameter int unsigned           TIMEOUT_W      = 24,
    parameter logic [TIMEOUT_W-1:0]  TIMEOUT_CYCLES = 24'd1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam logic [TIMEOUT_W-1:0] LAST = TIMEOUT_CYCLES - TIMEOUT_W'(1);

    logic [TIMEOUT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            count_q <= '0;
        end else if (enable_i && (count_q < LAST)) begin
            count_q <= count_q + TIMEOUT_W'(1);
        end
    end

    // Expiry is asserted during the TIMEOUT_CYCLES-th cycle so the FSM leaves on that edge.
    assign expired_o = enable_i && (count_q >= LAST);

endmodule

// File: rtl/npu_sequencer.sv
// NPU top-level phase controller: LOAD -> CONV -> DENSE with watchdog and command checking.
// Optional macro NPU_SEQ_PERF_EN enables the CONV+DENSE cycle counter on perf_cycles.
module npu_sequencer
    import npu_pkg::*;
#(
    parameter int unsigned           TIMEOUT_W      = 24,
    parameter logic [TIMEOUT_W-1:0]  TIMEOUT_CYCLES = 24'd1000000
) (
    input  logic              clk,
    input  logic              reset,
    npu_sequencer_if.master   bus
);

    state_t state_q, state_d;
    logic   load_start_q, load_start_d;
    logic   conv_start_q, conv_start_d;
    logic   dense_start_q, dense_start_d;
    logic   cmd_ready_q, cmd_ready_d;
    logic   err_to_q, err_to_d;
    logic   err_cmd_q, err_cmd_d;
    logic   seen_busy_q, seen_busy_d;
    logic   wd_clear, wd_expired, accept;
    cmd_t   cmd_in;

    assign cmd_in = cmd_t'(bus.cmd);
    assign accept = bus.cmd_valid && bus.cmd_ready;

    always_comb begin
        state_d       = state_q;
        load_start_d  = 1'b0;
        conv_start_d  = 1'b0;
        dense_start_d = 1'b0;
        err_to_d      = err_to_q;
        err_cmd_d     = err_cmd_q;
        seen_busy_d   = seen_busy_q || ((state_q == ST_LOAD) && bus.load_busy);

        unique case (state_q)
            ST_LOAD: begin
                if (seen_busy_q && !bus.load_busy) state_d = ST_LOADED;
                else if (wd_expired) begin
                    state_d  = ST_ERROR;
                    err_to_d = 1'b1;
                end
            end
            ST_CONV: begin
                if (bus.conv_done) begin
                    state_d       = ST_DENSE;
                    dense_start_d = 1'b1;
                end else if (wd_expired) begin
                    state_d  = ST_ERROR;
                    err_to_d = 1'b1;
                end
            end
            ST_DENSE: begin
                if (bus.dense_done) state_d = ST_DONE;
                else if (wd_expired) begin
                    state_d  = ST_ERROR;
                    err_to_d = 1'b1;
                end
            end
            default: ;
        endcase

        // Commands override phase progress; illegal ones only raise err_cmd and let the phase continue.
        if (accept) begin
            unique case (cmd_in)
                CMD_LOAD: begin
                    if (state_q inside {ST_IDLE, ST_LOADED, ST_DONE}) begin
                        state_d      = ST_LOAD;
                        load_start_d = 1'b1;
                        err_to_d     = 1'b0;
                        err_cmd_d    = 1'b0;
                        seen_busy_d  = 1'b0;
                    end else begin
                        err_cmd_d = 1'b1;
                    end
                end
                CMD_RUN: begin
                    if (state_q inside {ST_LOADED, ST_DONE}) begin
                        state_d      = ST_CONV;
                        conv_start_d = 1'b1;
                    end else begin
                        err_cmd_d = 1'b1;
                    end
                end
                CMD_ABORT: begin
                    state_d       = ST_IDLE;
                    load_start_d  = 1'b0;
                    dense_start_d = 1'b0;
                    seen_busy_d   = 1'b0;
                end
                default: ;
            endcase
        end

        cmd_ready_d = !(load_start_d || conv_start_d || dense_start_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            load_start_q  <= 1'b0;
            conv_start_q  <= 1'b0;
            dense_start_q <= 1'b0;
            cmd_ready_q   <= 1'b1;
            err_to_q      <= 1'b0;
            err_cmd_q     <= 1'b0;
            seen_busy_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            load_start_q  <= load_start_d;
            conv_start_q  <= conv_start_d;
            dense_start_q <= dense_start_d;
            cmd_ready_q   <= cmd_ready_d;
            err_to_q      <= err_to_d;
            err_cmd_q     <= err_cmd_d;
            seen_busy_q   <= seen_busy_d;
        end
    end

    assign wd_clear = in_phase(state_d) && (state_d != state_q);

    npu_watchdog #(
        .TIMEOUT_W      (TIMEOUT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (wd_clear),
        .enable_i  (in_phase(state_q)),
        .expired_o (wd_expired)
    );

`ifdef NPU_SEQ_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else if (conv_start_d) begin
            perf_q <= '0;
        end else if (((state_q == ST_CONV) || (state_q == ST_DENSE)) && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign bus.perf_cycles = perf_q;
`else
    assign bus.perf_cycles = '0;
`endif

    always_comb begin
        bus.status                                    = '0;
        bus.status[STATUS_STATE_LSB +: 3]             = state_q;
        bus.status[STATUS_BUSY]                       = in_phase(state_q);
        bus.status[STATUS_ERR_TO]                     = err_to_q;
        bus.status[STATUS_ERR_CMD]                    = err_cmd_q;
        bus.status[STATUS_DONE]                       = (state_q == ST_DONE);
    end

    // cmd_ready is forced low while reset is held so nothing is accepted in the reset cycle.
    assign bus.cmd_ready   = cmd_ready_q && !reset;
    assign bus.load_start  = load_start_q;
    assign bus.conv_start  = conv_start_q;
    assign bus.dense_start = dense_start_q;
    assign bus.busy        = in_phase(state_q);
    assign bus.irq         = (state_q == ST_DONE) || (state_q == ST_ERROR);

endmodule

// File: tb/tb_npu_sequencer.sv
// Directed scoreboard bench for npu_sequencer (watchdog shortened to 16 cycles).
module tb_npu_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;

    npu_sequencer_if bus ();

    npu_sequencer #(
        .TIMEOUT_W      (24),
        .TIMEOUT_CYCLES (24'd16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] P_LOAD  = 3'b001;
    localparam logic [2:0] P_CONV  = 3'b010;
    localparam logic [2:0] P_DENSE = 3'b100;

`ifdef NPU_SEQ_PERF_EN
    localparam logic [31:0] PERF_EXP = 32'd16;
`else
    localparam logic [31:0] PERF_EXP = 32'd0;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [2:0]  exp_q[$];
    logic [2:0]  mon_act, mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compares every start pulse against the next expected pulse in the queue.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!reset) begin
                mon_act = {bus.dense_start, bus.conv_start, bus.load_start};
                if (mon_act != 3'b000) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL unexpected_pulse: got %b expected none", mon_act);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (mon_act !== mon_exp) begin
                            n_bad++;
                            $display("FAIL start_pulse: got %b expected %b", mon_act, mon_exp);
                        end
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [1:0] c);
        int unsigned n;
        n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd = c;
        while (!bus.cmd_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL cmd_ready_timeout: got 0 expected 1 within 20 cycles");
        end
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd = 2'd0;
    endtask

    task automatic do_load();
        bus.load_busy = 1'b1;
        repeat (2) tick();
        bus.load_busy = 1'b0;
        tick();
    endtask

    initial begin
        bus.cmd_valid  = 1'b0;
        bus.cmd        = 2'd0;
        bus.load_busy  = 1'b0;
        bus.conv_done  = 1'b0;
        bus.dense_done = 1'b0;
        fork
            monitor();
        join_none

        repeat (2) @(posedge clk);
        #1;
        check("rst_status", {24'd0, bus.status}, 32'h00);
        check("rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        check("rst_irq", {31'd0, bus.irq}, 32'd0);
        check("rst_perf", bus.perf_cycles, 32'd0);
        reset = 1'b0;
        #1;
        check("post_rst_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

        // LOAD with a 5-cycle busy window
        exp_q.push_back(P_LOAD);
        send_cmd(2'd1);
        check("t1_load_state", {24'd0, bus.status}, 32'h09);
        check("t1_stall", {31'd0, bus.cmd_ready}, 32'd0);
        repeat (3) tick();
        check("t1_no_rise", {24'd0, bus.status}, 32'h09);
        bus.load_busy = 1'b1;
        repeat (5) tick();
        bus.load_busy = 1'b0;
        tick();
        check("t1_loaded", {24'd0, bus.status}, 32'h02);
        check("t1_ready_back", {31'd0, bus.cmd_ready}, 32'd1);

        // RUN: conv_done at +4, dense_done at +3
        exp_q.push_back(P_CONV);
        send_cmd(2'd2);
        check("t2_conv", {24'd0, bus.status}, 32'h0B);
        repeat (3) tick();
        exp_q.push_back(P_DENSE);
        bus.conv_done = 1'b1;
        tick();
        bus.conv_done = 1'b0;
        check("t2_dense", {24'd0, bus.status}, 32'h0C);
        repeat (2) tick();
        bus.dense_done = 1'b1;
        tick();
        bus.dense_done = 1'b0;
        check("t2_done", {24'd0, bus.status}, 32'h45);
        check("t2_irq", {31'd0, bus.irq}, 32'd1);
        bus.conv_done = 1'b1;
        tick();
        bus.conv_done = 1'b0;
        check("t2_stray_done", {24'd0, bus.status}, 32'h45);

        // ABORT, illegal RUN in IDLE, then LOAD clears err_cmd
        send_cmd(2'd3);
        check("t3_abort", {24'd0, bus.status}, 32'h00);
        send_cmd(2'd2);
        check("t3_bad_run", {24'd0, bus.status}, 32'h20);
        exp_q.push_back(P_LOAD);
        send_cmd(2'd1);
        check("t3_err_clear", {24'd0, bus.status}, 32'h09);
        do_load();
        check("t3_loaded", {24'd0, bus.status}, 32'h02);

        // CONV watchdog: still CONV after 15 cycles, ERROR after 16
        exp_q.push_back(P_CONV);
        send_cmd(2'd2);
        repeat (15) tick();
        check("t4_pre_timeout", {24'd0, bus.status}, 32'h0B);
        tick();
        check("t4_timeout", {24'd0, bus.status}, 32'h16);
        check("t4_irq", {31'd0, bus.irq}, 32'd1);
        send_cmd(2'd2);
        check("t4_run_in_error", {24'd0, bus.status}, 32'h36);
        send_cmd(2'd3);
        check("t4_abort", {24'd0, bus.status}, 32'h30);
        check("t4_irq_low", {31'd0, bus.irq}, 32'd0);

        // ABORT on the same edge as dense_done
        exp_q.push_back(P_LOAD);
        send_cmd(2'd1);
        do_load();
        exp_q.push_back(P_CONV);
        send_cmd(2'd2);
        tick();
        exp_q.push_back(P_DENSE);
        bus.conv_done = 1'b1;
        tick();
        bus.conv_done = 1'b0;
        tick();
        bus.dense_done = 1'b1;
        send_cmd(2'd3);
        bus.dense_done = 1'b0;
        check("t5_abort_wins", {24'd0, bus.status}, 32'h00);
        repeat (3) tick();
        check("t5_no_done", {24'd0, bus.status}, 32'h00);
        check("t5_irq", {31'd0, bus.irq}, 32'd0);

        // perf: 10 CONV cycles + 6 DENSE cycles
        exp_q.push_back(P_LOAD);
        send_cmd(2'd1);
        do_load();
        exp_q.push_back(P_CONV);
        send_cmd(2'd2);
        repeat (9) tick();
        exp_q.push_back(P_DENSE);
        bus.conv_done = 1'b1;
        tick();
        bus.conv_done = 1'b0;
        repeat (5) tick();
        bus.dense_done = 1'b1;
        tick();
        bus.dense_done = 1'b0;
        check("t6_done", {24'd0, bus.status}, 32'h45);
        check("t6_perf", bus.perf_cycles, PERF_EXP);
        repeat (3) tick();
        check("t6_perf_held", bus.perf_cycles, PERF_EXP);

        repeat (2) tick();
        check("pulses_outstanding", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
